lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store controller between the core's memory stage and the word-addressed data memory.
//  Accepts one byte-addressed request at a time and maps it onto word index, data and write strobe.
//  Sub-word stores are done as read-modify-write because the memory has no byte enables.
//  Loads are sign- or zero-extended per RV32I funct3.
// PARAMETERS
//  MEM_WORDS  64  data memory depth in 32-bit words (power of 2); word index wraps modulo MEM_WORDS
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   synchronous reset, active-high
//  req_i      in   1   request valid; accepted when req_i && ready_o
//  we_i       in   1   1 = store, 0 = load
//  size_i     in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  addr_i     in   32  byte address
//  wdata_i    in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  ready_o    out  1   controller idle, can accept
//  done_o     out  1   one-cycle completion pulse
//  rdata_o    out  32  extended load data; valid with done_o, held until next done_o
//  err_o      out  1   request rejected; valid with done_o, held until next done_o
//  mem_we_o   out  1   memory write enable
//  mem_a_o    out  32  memory word index = (addr>>2) mod MEM_WORDS, zero-extended
//  mem_wd_o   out  32  memory write data
//  mem_rd_i   in   32  memory read data, combinational, valid while mem_we_o=0
// BEHAVIOUR
//  Reset: state IDLE; ready_o=1; done_o, err_o, mem_we_o = 0; rdata_o, mem_a_o, mem_wd_o = 0.
//  mem_we_o is gated by !rst, so no write happens on an edge where rst=1, even mid-WRITE.
//  States: IDLE, ACCESS, WRITE, DONE. ready_o=1 only in IDLE.
//  Accept (cycle N): latch we, size, addr, wdata. Invalid size -> DONE with err.
//    Invalid sizes: 011, 11x, or a store with size 1xx.
//    Otherwise -> ACCESS.
//  ACCESS, load: mem_a driven, mem_we=0; capture mem_rd_i, extend -> DONE.
//    done_o at N+2.
//  ACCESS, SW: mem_we=1, mem_wd=wdata -> DONE; done_o at N+2.
//  ACCESS, SB/SH: read the word, merge the new lane(s) into a register -> WRITE.
//    WRITE: mem_we=1, mem_wd=merged word -> DONE; done_o at N+3.
//  Error path: done_o at N+1, err_o=1, rdata_o=0, no memory access.
//  DONE: done_o=1 for one cycle -> IDLE. Back-to-back requests: next accept in cycle after DONE.
//  Lanes are little-endian: byte k at [8k+7:8k], k=addr[1:0].
//    Half lanes are at [15:0] or [31:16] by addr[1].
//  Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend.
//  mem_a_o keeps its last value outside ACCESS/WRITE. mem_wd_o is meaningful only while mem_we_o=1.
//  req_i is ignored while ready_o=0; request inputs need not stay stable after accept.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: these accesses take the error path (err_o=1, done at N+1).
//    Affected: H/HU with addr[0]=1, and W with addr[1:0]!=0.
//  LSU_MISALIGN_TRAP_EN undefined: misaligned low bits are ignored.
//    H aligns to addr[1], W to addr[1:0]=00. err_o is set only for invalid size.
// TESTING
//  1. SW 0x10 data 0xDEADBEEF, then LW 0x10.
//     -> mem_a=4; rdata 0xDEADBEEF; done_o at N+2 for both.
//  2. SB 0x11 data 0xA5 over 0xDEADBEEF -> word 0xDEADA5EF, done N+3.
//     Then LB 0x11 -> 0xFFFFFFA5, LBU 0x11 -> 0x000000A5.
//  3. SH 0x12 data 0x8001 -> word 0x8001A5EF.
//     Then LH 0x12 -> 0xFFFF8001, LHU 0x12 -> 0x00008001.
//  4. LW 0x13 with the macro -> err_o=1, done N+1, no mem_we.
//     Same LW without the macro -> rdata = word at 0x10.
//  5. rst=1 in the WRITE cycle of an SB -> mem_we_o=0, memory word unchanged.
//     Next cycle: ready_o=1, all other outputs 0.
//  6. size 011 -> err_o=1 at N+1. SB with size 100 -> err_o=1.
//     LW 0x100 with MEM_WORDS=64 -> mem_a_o=0 (wrap).

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Core-side request/response and word-memory signals of the load/store controller.
// The slave modport is the controller itself; the master modport is the core plus memory.
interface lsu_ctrl_if;
  logic        req_i;
  logic        we_i;
  logic [2:0]  size_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mem_we_o;
  logic [31:0] mem_a_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;

  modport slave (
    input  req_i, we_i, size_i, addr_i, wdata_i, mem_rd_i,
    output ready_o, done_o, rdata_o, err_o, mem_we_o, mem_a_o, mem_wd_o
  );

  modport master (
    output req_i, we_i, size_i, addr_i, wdata_i, mem_rd_i,
    input  ready_o, done_o, rdata_o, err_o, mem_we_o, mem_a_o, mem_wd_o
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Byte-addressed load/store onto word memory; done 2 cycles after accept, 3 for SB/SH (RMW), 1 on error.
// One request in flight, ready only in IDLE; define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/W.
module lsu_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input logic       clk,
  input logic       rst,
  lsu_ctrl_if.slave bus
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  typedef struct packed {
    logic          we;
    logic [2:0]    size;
    logic [1:0]    lo;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
  } req_t;

  state_t        state_q, state_d;
  req_t          req_q;
  logic [AW-1:0] mem_a_q;
  logic [31:0]   rdata_q;
  logic [31:0]   merged_q;
  logic          err_q;

  logic          accept;
  logic          bad_req;
  logic          sub_word;
  logic [31:0]   load_ext;
  logic [31:0]   merged_d;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          unused_addr;

  assign unused_addr = ^bus.addr_i[31:AW+2];

  assign accept   = bus.req_i && (state_q == IDLE);
  assign sub_word = (req_q.size[1:0] != 2'b10);

  always_comb begin
    bad_req = (bus.size_i == 3'b011) || (bus.size_i[2:1] == 2'b11) ||
              (bus.we_i && bus.size_i[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.size_i[1:0] == 2'b01 && bus.addr_i[0]) ||
        (bus.size_i == 3'b010 && bus.addr_i[1:0] != 2'b00))
      bad_req = 1'b1;
`endif
  end

  // Lane selection ignores the misaligned low bits when trapping is off.
  always_comb begin
    byte_v   = bus.mem_rd_i[{req_q.lo, 3'b000} +: 8];
    half_v   = bus.mem_rd_i[{req_q.lo[1], 4'b0000} +: 16];
    load_ext = bus.mem_rd_i;
    case (req_q.size[1:0])
      2'b00:   load_ext = req_q.size[2] ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   load_ext = req_q.size[2] ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
      default: load_ext = bus.mem_rd_i;
    endcase
  end

  always_comb begin
    merged_d = bus.mem_rd_i;
    if (req_q.size[1:0] == 2'b00)
      merged_d[{req_q.lo, 3'b000} +: 8] = req_q.wdata[7:0];
    else
      merged_d[{req_q.lo[1], 4'b0000} +: 16] = req_q.wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    bus.ready_o  = 1'b0;
    bus.done_o   = 1'b0;
    bus.mem_we_o = 1'b0;
    bus.mem_wd_o = 32'h0;
    case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.req_i) state_d = bad_req ? DONE : ACCESS;
      end
      ACCESS: begin
        if (req_q.we && sub_word) begin
          state_d = WRITE;
        end else begin
          state_d = DONE;
          if (req_q.we) begin
            bus.mem_we_o = 1'b1;
            bus.mem_wd_o = req_q.wdata;
          end
        end
      end
      WRITE: begin
        bus.mem_we_o = 1'b1;
        bus.mem_wd_o = merged_q;
        state_d      = DONE;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_d    = IDLE;
      end
    endcase
    // A reset landing mid-write must not corrupt memory.
    if (rst) bus.mem_we_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= '0;
      mem_a_q  <= '0;
      rdata_q  <= 32'h0;
      merged_q <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        req_q.we    <= bus.we_i;
        req_q.size  <= bus.size_i;
        req_q.lo    <= bus.addr_i[1:0];
        req_q.idx   <= bus.addr_i[AW+1:2];
        req_q.wdata <= bus.wdata_i;
        if (bad_req) begin
          err_q   <= 1'b1;
          rdata_q <= 32'h0;
        end else begin
          mem_a_q <= bus.addr_i[AW+1:2];
        end
      end
      if (state_q == ACCESS) begin
        if (!req_q.we) begin
          rdata_q <= load_ext;
          err_q   <= 1'b0;
        end else if (sub_word) begin
          merged_q <= merged_d;
        end else begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
      end
      if (state_q == WRITE) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end

  assign bus.rdata_o = rdata_q;
  assign bus.err_o   = err_q;
  assign bus.mem_a_o = {{(32-AW){1'b0}}, mem_a_q};

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboarded bench for lsu_ctrl with a word-addressed memory model behind it.
module tb_lsu_ctrl;
  logic clk;
  logic rst;
  logic tb_clr;
  int   checks;
  int   errors;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [31:0] mem_a;
    bit          is_load;
  } exp_t;

  exp_t sb[$];

  lsu_ctrl_if ifc ();

  lsu_ctrl #(.MEM_WORDS(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  assign ifc.mem_rd_i = mem[ifc.mem_a_o[5:0]];

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (ifc.mem_we_o) begin
      mem[ifc.mem_a_o[5:0]] <= ifc.mem_wd_o;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input string name);
    exp_t e;
    exp_t got;
    int   w;
    int   lat;
    bit   we_seen;
    bit   done_seen;
    w = 0;
    while (ifc.ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (ifc.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: got %b want 1 within 20 cycles", name, ifc.ready_o);
      return;
    end
    ifc.req_i   = 1'b1;
    ifc.we_i    = we;
    ifc.size_i  = size;
    ifc.addr_i  = addr;
    ifc.wdata_i = wdata;
    e.rdata   = exp_rdata;
    e.err     = exp_err;
    e.lat     = exp_lat;
    e.mem_a   = (addr >> 2) & 32'd63;
    e.is_load = !we;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Junk store held during the busy period must be ignored.
    ifc.we_i    = 1'b1;
    ifc.size_i  = 3'b010;
    ifc.addr_i  = 32'h0000_00F0;
    ifc.wdata_i = $urandom;
    lat = 0;
    we_seen = 1'b0;
    done_seen = 1'b0;
    while (!done_seen && lat < 10) begin
      @(negedge clk);
      lat++;
      if (ifc.mem_we_o === 1'b1) we_seen = 1'b1;
      if (ifc.done_o === 1'b1) done_seen = 1'b1;
    end
    ifc.req_i = 1'b0;
    got = sb.pop_front();
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL %s done: not seen within 10 cycles", name);
      return;
    end
    checks++;
    if (lat !== got.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, got.lat);
    end
    checks++;
    if (ifc.err_o !== got.err) begin
      errors++;
      $display("FAIL %s err_o: got %b want %b", name, ifc.err_o, got.err);
    end
    if (got.err || got.is_load) begin
      checks++;
      if (ifc.rdata_o !== got.rdata) begin
        errors++;
        $display("FAIL %s rdata_o: got %h want %h", name, ifc.rdata_o, got.rdata);
      end
    end
    if (got.err) begin
      checks++;
      if (we_seen) begin
        errors++;
        $display("FAIL %s mem_we on error: got 1 want 0", name);
      end
    end else begin
      checks++;
      if (ifc.mem_a_o !== got.mem_a) begin
        errors++;
        $display("FAIL %s mem_a_o: got %h want %h", name, ifc.mem_a_o, got.mem_a);
      end
    end
  endtask

  task automatic check_mem(input int idx, input logic [31:0] want, input string name);
    checks++;
    if (mem[idx] !== want) begin
      errors++;
      $display("FAIL %s mem[%0d]: got %h want %h", name, idx, mem[idx], want);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (ifc.ready_o !== 1'b1 || ifc.done_o !== 1'b0 || ifc.err_o !== 1'b0 ||
        ifc.mem_we_o !== 1'b0 || ifc.rdata_o !== 32'h0 || ifc.mem_a_o !== 32'h0 ||
        ifc.mem_wd_o !== 32'h0) begin
      errors++;
      $display("FAIL %s outputs: rdy=%b done=%b err=%b we=%b rdata=%h a=%h wd=%h want 1,0,0,0,0,0,0",
               name, ifc.ready_o, ifc.done_o, ifc.err_o, ifc.mem_we_o, ifc.rdata_o,
               ifc.mem_a_o, ifc.mem_wd_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_clr = 1'b0;
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");
  endtask

  task automatic test_word();
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_10");
    check_mem(4, 32'hDEADBEEF, "sw_10");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw_10");
  endtask

  task automatic test_byte();
    do_req(1'b1, 3'b000, 32'h11, 32'h000000A5, 32'h0, 1'b0, 3, "sb_11");
    check_mem(4, 32'hDEADA5EF, "sb_11");
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0, 2, "lb_11");
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h000000A5, 1'b0, 2, "lbu_11");
  endtask

  task automatic test_half();
    do_req(1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 1'b0, 3, "sh_12");
    check_mem(4, 32'h8001A5EF, "sh_12");
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, "lh_12");
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 1'b0, 2, "lhu_12");
  endtask

  task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
    do_req(1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, "lw_13_trap");
    do_req(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1, "lh_13_trap");
`else
    do_req(1'b0, 3'b010, 32'h13, 32'h0, 32'h8001A5EF, 1'b0, 2, "lw_13");
    do_req(1'b0, 3'b001, 32'h13, 32'h0, 32'hFFFF8001, 1'b0, 2, "lh_13");
`endif
  endtask

  task automatic test_reset_write();
    while (ifc.ready_o !== 1'b1) @(negedge clk);
    ifc.req_i   = 1'b1;
    ifc.we_i    = 1'b1;
    ifc.size_i  = 3'b000;
    ifc.addr_i  = 32'h11;
    ifc.wdata_i = 32'h0000003C;
    @(posedge clk);
    @(negedge clk);
    ifc.req_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ifc.mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_write mem_we_o: got %b want 0", ifc.mem_we_o);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("rst_write_next");
    check_mem(4, 32'h8001A5EF, "rst_write");
  endtask

  task automatic test_errors();
    do_req(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, "size_011");
    do_req(1'b1, 3'b100, 32'h10, 32'hFF, 32'h0, 1'b1, 1, "sb_size_100");
    do_req(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1, "size_110");
    do_req(1'b1, 3'b101, 32'h10, 32'hFF, 32'h0, 1'b1, 1, "sh_size_101");
    check_mem(4, 32'h8001A5EF, "err_stores");
    do_req(1'b1, 3'b010, 32'h0, 32'h12345678, 32'h0, 1'b0, 2, "sw_0");
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 1'b0, 2, "lw_100_wrap");
  endtask

  task automatic test_back_to_back();
    int          idx;
    int          k;
    logic [31:0] d;
    logic [7:0]  b;
    for (int i = 0; i < 8; i++) begin
      idx = 16 + $urandom_range(0, 15);
      d = $urandom;
      shadow[idx] = d;
      do_req(1'b1, 3'b010, idx * 4, d, 32'h0, 1'b0, 2, "rnd_sw");
      if (i == 0) begin
        checks++;
        if (ifc.ready_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b ready in DONE: got %b want 0", ifc.ready_o);
        end
        @(negedge clk);
        checks++;
        if (ifc.ready_o !== 1'b1 || ifc.done_o !== 1'b0) begin
          errors++;
          $display("FAIL b2b after DONE: ready %b done %b want 1 0", ifc.ready_o, ifc.done_o);
        end
      end
      do_req(1'b0, 3'b010, idx * 4, 32'h0, shadow[idx], 1'b0, 2, "rnd_lw");
      k = $urandom_range(0, 3);
      b = shadow[idx] >> (8 * k);
      do_req(1'b0, 3'b000, idx * 4 + k, 32'h0, {{24{b[7]}}, b}, 1'b0, 2, "rnd_lb");
    end
    check_mem(60, 32'h0, "ignored_junk");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    errors      = 0;
    tb_clr      = 1'b1;
    rst         = 1'b1;
    ifc.req_i   = 1'b0;
    ifc.we_i    = 1'b0;
    ifc.size_i  = 3'b000;
    ifc.addr_i  = 32'h0;
    ifc.wdata_i = 32'h0;
    for (int i = 0; i < 64; i++) shadow[i] = 32'h0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reset_write();
    test_errors();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
